// File: rtl/iob_ram_port_arb.sv
// iob_ram_port_arb: two-requester arbiter in front of one byte-write-enable RAM port.
// Define IOB_RAM_ARB_RR_EN for round-robin tie breaking; otherwise M0 always wins ties.
module iob_ram_port_arb #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,

    output logic                  ram_en,
    output logic [DATA_W/8-1:0]   ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_din,
    input  logic [DATA_W-1:0]     ram_dout
);

    localparam int N_REQ  = 2;
    localparam int STRB_W = DATA_W / 8;

    logic [N_REQ-1:0]  w_valid;
    logic [N_REQ-1:0]  w_grant;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [STRB_W-1:0] w_sel_wstrb;
    logic              w_sel_read;
    logic [N_REQ-1:0]  r_rvalid;

    assign w_valid = {m1_valid, m0_valid};

`ifdef IOB_RAM_ARB_RR_EN
    logic r_last;  // index of the most recently granted requester

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (|w_grant) begin
            r_last <= w_grant[1];
        end
    end

    always_comb begin
        w_grant = w_valid;
        if (&w_valid) begin
            w_grant = r_last ? 2'b01 : 2'b10;
        end
    end
`else
    always_comb begin
        w_grant = w_valid;
        if (&w_valid) begin
            w_grant = 2'b01;
        end
    end
`endif

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        w_sel_wstrb = m0_wstrb;
        if (w_grant[1]) begin
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
            w_sel_wstrb = m1_wstrb;
        end
    end

    assign w_sel_read = ~|w_sel_wstrb;

    assign m0_ready = w_grant[0];
    assign m1_ready = w_grant[1];
    assign ram_en   = |w_grant;
    assign ram_we   = ram_en ? w_sel_wstrb : '0;
    assign ram_addr = w_sel_addr;
    assign ram_din  = w_sel_wdata;

    // Read response tracks the RAM's one-cycle latency; reset discards any in flight.
    // NOTE: sequential state uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_grant & {N_REQ{w_sel_read}};
        end
    end

    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_iob_ram_port_arb.sv
// Self-checking bench for iob_ram_port_arb with a behavioural RAM and reference model.
// Expectations follow IOB_RAM_ARB_RR_EN when the bench is built with that macro.
module tb_iob_ram_port_arb;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m0_valid, m1_valid;
    logic              m0_ready, m1_ready;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [STRB_W-1:0] m0_wstrb, m1_wstrb;
    logic              m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              ram_en;
    logic [STRB_W-1:0] ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    iob_ram_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        logic [7:0] lo;
        lo = 8'(i);
        return {8'hA5, lo, 8'h3C, lo ^ 8'h77};
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < STRB_W; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Behavioural single-port RAM, read-first, registered output
    logic              tb_load;
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (ram_en) begin
            ram_dout <= mem[ram_addr];
            for (int b = 0; b < STRB_W; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                ref_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        if (k == 0) begin
            m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc_end();
    endtask

    typedef struct {
        logic              v0, v1;
        logic [STRB_W-1:0] s0, s1;
        logic              e_r0, e_r1, e_en;
        logic [STRB_W-1:0] e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_din;
    } vec_t;

    vec_t vecs [6];

    // Random-phase requester state
    logic              pend   [2];
    logic [ADDR_W-1:0] p_addr [2];
    logic [DATA_W-1:0] p_wdata[2];
    logic [STRB_W-1:0] p_wstrb[2];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 10'h0A1, 32'h11111111};
        vecs[2] = '{1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b1, 4'hF, 10'h0B2, 32'h22222222};
        vecs[3] = '{1'b1, 1'b1, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 4'h3, 10'h0A1, 32'h11111111};
        vecs[4] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 10'h0B2, 32'h22222222};
        vecs[5] = '{1'b1, 1'b0, 4'h8, 4'h6, 1'b1, 1'b0, 1'b1, 4'h8, 10'h0A1, 32'h11111111};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        tb_load = 1'b1;
        rst_n   = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        tb_load = 1'b0;
        @(negedge clk);
        check("reset m0_rvalid", m0_rvalid, 0);
        check("reset m1_rvalid", m1_rvalid, 0);
        check("reset ram_en idle", ram_en, 0);
        check("reset ram_we idle", ram_we, 0);
        rst_n = 1'b1;
        cyc_end();

        // Combinational vectors inside one clock period (pointer stays at reset value)
        for (int i = 0; i < 6; i++) begin
            drive(0, vecs[i].v0, 10'h0A1, 32'h11111111, vecs[i].s0);
            drive(1, vecs[i].v1, 10'h0B2, 32'h22222222, vecs[i].s1);
            #1;
            check($sformatf("vec%0d m0_ready", i), m0_ready, vecs[i].e_r0);
            check($sformatf("vec%0d m1_ready", i), m1_ready, vecs[i].e_r1);
            check($sformatf("vec%0d ram_en", i), ram_en, vecs[i].e_en);
            check($sformatf("vec%0d ram_we", i), ram_we, vecs[i].e_we);
            if (vecs[i].e_en) begin
                check($sformatf("vec%0d ram_addr", i), ram_addr, vecs[i].e_addr);
                check($sformatf("vec%0d ram_din", i), ram_din, vecs[i].e_din);
            end
        end
        idle();
        cyc_end();

        // Sole M0 read of 0x005
        drive(0, 1'b1, 10'h005, 32'h0, 4'h0);
        @(negedge clk);
        check("rd5 m0_ready", m0_ready, 1);
        check("rd5 m1_ready", m1_ready, 0);
        check("rd5 ram_en", ram_en, 1);
        check("rd5 ram_we", ram_we, 0);
        check("rd5 ram_addr", ram_addr, 10'h005);
        cyc_end();
        idle();
        @(negedge clk);
        check("rd5 m0_rvalid", m0_rvalid, 1);
        check("rd5 m1_rvalid", m1_rvalid, 0);
        check("rd5 m0_rdata", m0_rdata, ref_mem[5]);
        cyc_end();
        @(negedge clk);
        check("rd5 m0_rvalid single pulse", m0_rvalid, 0);
        cyc_end();

        // M1 partial write then M0 readback
        drive(1, 1'b1, 10'h010, 32'hAABBCCDD, 4'b0101);
        @(negedge clk);
        check("wr10 m1_ready", m1_ready, 1);
        check("wr10 ram_we", ram_we, 4'b0101);
        check("wr10 ram_din", ram_din, 32'hAABBCCDD);
        check("wr10 ram_addr", ram_addr, 10'h010);
        ref_mem[16] = merge(ref_mem[16], 32'hAABBCCDD, 4'b0101);
        cyc_end();
        drive(1, 1'b0, '0, '0, '0);
        drive(0, 1'b1, 10'h010, 32'h0, 4'h0);
        @(negedge clk);
        check("wr10 no m0_rvalid", m0_rvalid, 0);
        check("wr10 no m1_rvalid", m1_rvalid, 0);
        cyc_end();
        idle();
        @(negedge clk);
        check("rd10 m0_rvalid", m0_rvalid, 1);
        check("rd10 m0_rdata", m0_rdata, {init_word(16)[31:24], 8'hBB, init_word(16)[15:8], 8'hDD});
        cyc_end();

        // M1-only grant leaves the pointer at M1, then a 4-cycle tie
        drive(1, 1'b1, 10'h020, 32'h0, 4'h0);
        @(negedge clk);
        check("rd20 m1_ready", m1_ready, 1);
        cyc_end();
        drive(1, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("rd20 m1_rvalid", m1_rvalid, 1);
        check("rd20 m0_rvalid", m0_rvalid, 0);
        check("rd20 m1_rdata", m1_rdata, ref_mem[32]);
        cyc_end();
        drive(0, 1'b1, 10'h030, 32'h0, 4'h0);
        drive(1, 1'b1, 10'h031, 32'h0, 4'h0);
        for (int c = 0; c < 4; c++) begin
            logic e0;
`ifdef IOB_RAM_ARB_RR_EN
            e0 = (c % 2 == 0);
`else
            e0 = 1'b1;
`endif
            @(negedge clk);
            check($sformatf("tie%0d m0_ready", c), m0_ready, e0);
            check($sformatf("tie%0d m1_ready", c), m1_ready, !e0);
            cyc_end();
        end
        idle();
        cyc_end();

        // Back-to-back reads with routing
        drive(0, 1'b1, 10'h001, 32'h0, 4'h0);
        @(negedge clk);
        check("b2b m0_ready", m0_ready, 1);
        cyc_end();
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b1, 10'h002, 32'h0, 4'h0);
        @(negedge clk);
        check("b2b m1_ready", m1_ready, 1);
        check("b2b m0_rvalid", m0_rvalid, 1);
        check("b2b m1_rvalid early", m1_rvalid, 0);
        check("b2b m0_rdata", m0_rdata, ref_mem[1]);
        cyc_end();
        idle();
        @(negedge clk);
        check("b2b m1_rvalid", m1_rvalid, 1);
        check("b2b m0_rvalid late", m0_rvalid, 0);
        check("b2b m1_rdata", m1_rdata, ref_mem[2]);
        cyc_end();

        // Reset right after an accepted M0 read drops the response
        drive(0, 1'b1, 10'h003, 32'h0, 4'h0);
        @(negedge clk);
        check("rst rd m0_ready", m0_ready, 1);
        cyc_end();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        check("in reset m0_rvalid", m0_rvalid, 0);
        check("in reset m1_rvalid", m1_rvalid, 0);
        cyc_end();
        @(negedge clk);
        rst_n = 1'b1;
        cyc_end();
        @(negedge clk);
        check("post reset m0_rvalid", m0_rvalid, 0);
        check("post reset m1_rvalid", m1_rvalid, 0);
        cyc_end();
        drive(0, 1'b1, 10'h004, 32'h0, 4'h0);
        drive(1, 1'b1, 10'h006, 32'h0, 4'h0);
        @(negedge clk);
        check("post reset tie m0_ready", m0_ready, 1);
        check("post reset tie m1_ready", m1_ready, 0);
        idle();
        cyc_end();

        // Randomized traffic against the reference model
        do_reset();
        ref_last = 1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        begin
            logic [1:0]        exp_rv;
            logic [DATA_W-1:0] exp_data;
            exp_rv   = 2'b00;
            exp_data = '0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                int g;
                for (int k = 0; k < 2; k++) begin
                    if (!pend[k] && $urandom_range(0, 99) < 65) begin
                        pend[k]    = 1'b1;
                        p_addr[k]  = ADDR_W'($urandom_range(0, 15));
                        p_wdata[k] = $urandom;
                        p_wstrb[k] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    end
                    drive(k, pend[k], p_addr[k], p_wdata[k], p_wstrb[k]);
                end
                if (pend[0] && pend[1]) begin
`ifdef IOB_RAM_ARB_RR_EN
                    g = (ref_last == 0) ? 1 : 0;
`else
                    g = 0;
`endif
                end else if (pend[0]) g = 0;
                else if (pend[1])     g = 1;
                else                  g = -1;

                @(negedge clk);
                check("rnd m0_ready", m0_ready, g == 0);
                check("rnd m1_ready", m1_ready, g == 1);
                check("rnd ram_en", ram_en, g >= 0);
                check("rnd m0_rvalid", m0_rvalid, exp_rv[0]);
                check("rnd m1_rvalid", m1_rvalid, exp_rv[1]);
                if (exp_rv[0]) check("rnd m0_rdata", m0_rdata, exp_data);
                if (exp_rv[1]) check("rnd m1_rdata", m1_rdata, exp_data);
                exp_rv = 2'b00;
                if (g >= 0) begin
                    check("rnd ram_addr", ram_addr, p_addr[g]);
                    check("rnd ram_we", ram_we, p_wstrb[g]);
                    check("rnd ram_din", ram_din, p_wdata[g]);
                    if (p_wstrb[g] == 0) begin
                        exp_rv[g] = 1'b1;
                        exp_data  = ref_mem[p_addr[g]];
                    end else begin
                        ref_mem[p_addr[g]] = merge(ref_mem[p_addr[g]], p_wdata[g], p_wstrb[g]);
                    end
                    ref_last = g;
                    pend[g]  = 1'b0;
                end else begin
                    check("rnd ram_we idle", ram_we, 0);
                end
                cyc_end();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
